// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits complete with zero added latency; misses stall the CPU for write-back and line fill.
// The CPU holds its request while cpu_stall_o is high; memory completes each line transfer with a one-cycle ack.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 27 - INDEX_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

  state_t state;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags  [LINES];
  logic [255:0]     lines [LINES];

  // Address decode; the two byte-offset bits are not used by a word cache.
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         word;
  logic               unused_byte_ofs;

  assign idx             = cpu_addr_i[INDEX_W+4:5];
  assign tag             = cpu_addr_i[31:INDEX_W+5];
  assign word            = cpu_addr_i[4:2];
  assign unused_byte_ofs = ^cpu_addr_i[1:0];

  logic [TAG_W-1:0] cur_tag;
  logic [255:0]     cur_line;
  logic [31:0]      sel_word;
  logic             req;
  logic             hit;

  assign cur_tag  = tags[idx];
  assign cur_line = lines[idx];
  assign sel_word = cur_line[{word, 5'b0} +: 32];
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit      = req & valid[idx] & (cur_tag == tag);

  // Merge the store word into the indexed line for a write hit.
  logic [255:0] wr_line;
  always_comb begin
    wr_line = cur_line;
    wr_line[{word, 5'b0} +: 32] = cpu_data_i;
  end

  // Miss sequencing plus valid/dirty bookkeeping; reset abandons any in-flight miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && cpu_MemWrite_i) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            state <= MISS;
          end
        end
        MISS: begin
          state <= (valid[idx] && dirty[idx]) ? WRITEBACK : READMISS;
        end
        WRITEBACK: begin
          if (mem_ack_i) state <= READMISS;
        end
        READMISS: begin
          if (mem_ack_i) state <= READMISSOK;
        end
        READMISSOK: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; they only change on a store hit or a completed fill.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == IDLE && hit && cpu_MemWrite_i) begin
        lines[idx] <= wr_line;
      end else if (state == READMISSOK) begin
        lines[idx] <= mem_data_i;
        tags[idx]  <= tag;
      end
    end
  end

  // Memory request strobes come straight from the state register so they never glitch.
  assign mem_enable_o = (state == WRITEBACK) || (state == READMISS);
  assign mem_write_o  = (state == WRITEBACK);

  // Memory address/data are only meaningful while a transfer is in flight.
  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state == WRITEBACK) begin
      mem_addr_o = {cur_tag, idx, 5'b0};
      mem_data_o = cur_line;
    end else if (state == READMISS) begin
      mem_addr_o = {tag, idx, 5'b0};
    end
  end

  assign cpu_stall_o = (state != IDLE) | (req & ~hit);
  assign cpu_data_o  = (state == IDLE && cpu_MemRead_i && !cpu_MemWrite_i && hit) ? sel_word : 32'h0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural line memory with a 9-cycle ack, flat shadow memory as reference.
// Table-driven access vectors plus hand-written reset/dual-request/spurious-ack sequences.
// Load results are queued at issue and popped when the cache drops stall.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_rd = 1'b0;
  logic         cpu_wr = 1'b0;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_en;
  logic         mem_we;
  logic [255:0] mem_rdata = '0;
  logic         model_ack = 1'b0;
  logic         spur_ack = 1'b0;
  logic         mem_ack;

  assign mem_ack = model_ack | spur_ack;

  dcache_ctrl #(.LINES(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
    .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_we),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  int n_vec = 0;
  int n_err = 0;

  // Initial content of any untouched word.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Backing memory: lines written back by the cache, otherwise the pattern.
  logic [255:0] memline [logic [26:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (memline.exists(a[31:5])) return memline[a[31:5]];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = pat({a[31:5], w[2:0], 2'b00});
    return l;
  endfunction

  // Reference view: what the CPU should read back from every word.
  logic [31:0] shw [logic [29:0]];

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shw.exists(a[31:2]) ? shw[a[31:2]] : pat(a);
  endfunction

  function automatic logic [255:0] shadow_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = shadow_rd({a[31:5], w[2:0], 2'b00});
    return l;
  endfunction

  // Memory model: acks in the 10th cycle it sees enable, then needs enable to drop/restart.
  int mcnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      model_ack <= 1'b0;
      mcnt      <= 0;
    end else if (model_ack) begin
      model_ack <= 1'b0;
      mcnt      <= 0;
    end else if (mem_en) begin
      if (mcnt == 8) begin
        model_ack <= 1'b1;
        mcnt      <= 0;
        if (mem_we) memline[mem_addr[31:5]] = mem_wdata;
        else        mem_rdata <= mem_line(mem_addr);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  logic [31:0] exp_q [$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One CPU access held until stall drops; starts and ends just after a rising edge.
  task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input int exp_stall,
                           input logic [31:0] exp_wb, input string nm);
    int cyc;
    bit done;
    logic saw_wb, saw_fill, fill_wr_ok;
    logic [31:0] wb_a, fill_a;
    logic [255:0] wb_d;
    cyc = 0; done = 0; saw_wb = 0; saw_fill = 0; fill_wr_ok = 1;
    wb_a = '0; fill_a = '0; wb_d = '0;
    cpu_addr = addr; cpu_wdata = data; cpu_rd = re; cpu_wr = we;
    if (re && !we) exp_q.push_back(shadow_rd(addr));
    while (!done) begin
      @(negedge clk);
      if (!stall || cyc > 200) begin
        done = 1;
      end else begin
        if (mem_en && mem_we) begin saw_wb = 1; wb_a = mem_addr; wb_d = mem_wdata; end
        if (mem_en && !mem_we) begin saw_fill = 1; fill_a = mem_addr; end
        cyc++;
      end
    end
    check({nm, ".stall_cycles"}, cyc, exp_stall);
    if (re && !we) check({nm, ".load_data"}, cpu_rdata, exp_q.pop_front());
    if (exp_stall > 0) check({nm, ".fill_addr"}, {saw_fill, fill_a}, {1'b1, addr[31:5], 5'b0});
    if (exp_wb != NONE) begin
      check({nm, ".wb_addr"}, {saw_wb, wb_a}, {1'b1, exp_wb});
      check({nm, ".wb_data"}, wb_d, shadow_line(exp_wb));
    end else if (exp_stall > 0) begin
      check({nm, ".no_wb"}, saw_wb, 1'b0);
    end
    if (we) shw[addr[31:2]] = data;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic [31:0] wb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Index bits are [9:5] with 32 lines: 0x40/0x440 share index 2, 0x80/0x480 index 4.
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          13, NONE};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,   0, NONE};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,           0, NONE};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,           0, NONE};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,          23, 32'h0000_0040};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          13, NONE};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678,  13, NONE};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,           0, NONE};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0480, 32'h0,          23, 32'h0000_0080};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,          13, NONE};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_003C, 32'hCAFE_F00D,  13, NONE};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_003C, 32'h0,           0, NONE};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          13, NONE};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.cpu_data", cpu_rdata, 32'h0);
    check("rst.stall", stall, 1'b0);
    check("rst.mem_enable", mem_en, 1'b0);
    check("rst.mem_write", mem_we, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_data", mem_wdata, 256'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_access(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].wb,
                $sformatf("vec%0d", i));
    end

    // Read and write together on a hit behaves as a store with no load data.
    cpu_addr = 32'h0000_0048; cpu_wdata = 32'h1111_2222; cpu_rd = 1'b1; cpu_wr = 1'b1;
    @(negedge clk);
    check("both.stall", stall, 1'b0);
    check("both.cpu_data", cpu_rdata, 32'h0);
    shw[30'h12] = 32'h1111_2222;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, NONE, "both_readback");

    // An ack pulse while idle must not start anything.
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur.mem_enable", mem_en, 1'b0);
    check("spur.stall", stall, 1'b0);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, NONE, "spur_hit");

    // Reset in cycle 5 of a clean miss, then the same load must miss again.
    cpu_addr = 32'h0000_0100; cpu_rd = 1'b1; cpu_wr = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rstmiss.enable_before", {mem_en, mem_we}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
    check("rstmiss.mem_enable", mem_en, 1'b0);
    check("rstmiss.stall", stall, 1'b0);
    check("rstmiss.mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 13, NONE, "rstmiss_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
